// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte-lane stores, WAIT_CYCLES wait states, req/ack handshake.
// Optional macro DMEM_ADDR_CHECK_EN: out-of-range addresses complete with err_o instead of wrapping.
module dmem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic        ack_o,
  output logic [31:0] data_o,
  output logic        err_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;
  logic                  w_ack_nxt;
  logic [31:0]           w_rdata_nxt;
  logic                  w_err_nxt;

  logic                  r_we;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [3:0]            r_sel;
  logic [31:0]           r_wdata;
  logic                  r_oor;
  logic                  w_oor;
  logic                  w_take;

  logic [31:0]           r_mem [2**DEPTH_LOG2];

`ifdef DMEM_ADDR_CHECK_EN
  assign w_oor = |addr_i[31:DEPTH_LOG2+2];
  logic w_unused_addr;
  assign w_unused_addr = ^addr_i[1:0];
`else
  assign w_oor = 1'b0;
  logic w_unused_addr;
  assign w_unused_addr = ^{addr_i[31:DEPTH_LOG2+2], addr_i[1:0]};
`endif

  assign w_take = (r_state == S_IDLE) && req_i;

  // Request fields are captured once; later changes on the inputs are ignored.
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_we    <= we_i;
      r_idx   <= addr_i[DEPTH_LOG2+1:2];
      r_sel   <= sel_i;
      r_wdata <= data_i;
      r_oor   <= w_oor;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      ack_o   <= 1'b0;
      data_o  <= 32'h0000_0000;
      err_o   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      ack_o   <= w_ack_nxt;
      data_o  <= w_rdata_nxt;
      err_o   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack_nxt   = 1'b0;
    w_rdata_nxt = 32'h0000_0000;
    w_err_nxt   = 1'b0;
    busy_o      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_i) begin
          busy_o      = 1'b1;
          w_cnt_nxt   = 4'(WAIT_CYCLES);
          w_state_nxt = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        busy_o    = 1'b1;
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        busy_o      = 1'b1;
        w_ack_nxt   = 1'b1;
        w_err_nxt   = r_oor;
        w_rdata_nxt = (r_we || r_oor) ? 32'h0000_0000 : r_mem[r_idx];
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        // req_i deliberately not looked at here; a held request is taken in IDLE.
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && (r_state == S_ACCESS) && r_we && !r_oor) begin
      for (int k = 0; k < 4; k++) begin
        if (r_sel[k]) r_mem[r_idx][8*k +: 8] <= r_wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with 2 wait states, one with none.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst, req, req0, we;
  logic [31:0] addr, wdata;
  logic [3:0]  sel;
  logic        ack, err, busy;
  logic [31:0] rdata;
  logic        ack0, err0, busy0;
  logic [31:0] rdata0;

  int checks = 0;
  int errors = 0;
  int acks2  = 0;
  int acks0  = 0;

  logic [32:0] q2[$];
  logic [32:0] q0[$];
  logic [32:0] e2, e0;
  logic [31:0] mdl [1024];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .sel_i(sel),
    .data_i(wdata), .ack_o(ack), .data_o(rdata), .err_o(err), .busy_o(busy)
  );

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_i(req0), .we_i(we), .addr_i(addr), .sel_i(sel),
    .data_i(wdata), .ack_o(ack0), .data_o(rdata0), .err_o(err0), .busy_o(busy0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic oor(input logic [31:0] a);
`ifdef DMEM_ADDR_CHECK_EN
    return |a[31:12];
`else
    return 1'b0;
`endif
  endfunction

  // Expected {err, data} for a transaction; stores update the reference memory.
  function automatic logic [32:0] model(input logic w, input logic [31:0] a,
                                        input logic [3:0] s, input logic [31:0] d);
    if (oor(a)) return {1'b1, 32'h0};
    if (w) begin
      for (int k = 0; k < 4; k++)
        if (s[k]) mdl[a[11:2]][8*k +: 8] = d[8*k +: 8];
      return 33'h0;
    end
    return {1'b0, mdl[a[11:2]]};
  endfunction

  always @(negedge clk) begin
    if (ack) begin
      acks2++;
      if (q2.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
      else begin
        e2 = q2.pop_front();
        check("rdata", rdata, e2[31:0]);
        check("err", {31'b0, err}, {31'b0, e2[32]});
      end
    end
  end

  always @(negedge clk) begin
    if (ack0) begin
      acks0++;
      if (q0.size() == 0) check("unexpected_ack0", 32'd1, 32'd0);
      else begin
        e0 = q0.pop_front();
        check("rdata0", rdata0, e0[31:0]);
        check("err0", {31'b0, err0}, {31'b0, e0[32]});
      end
    end
  end

  // Ack is expected on the 4th edge counting the sampling edge as the first.
  task automatic txn2(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    int  n;
    logic got;
    @(negedge clk);
    we = w; addr = a; sel = s; wdata = d; req = 1'b1;
    q2.push_back(model(w, a, s, d));
    #1 check("busy_req", busy, 1);
    @(posedge clk);
    n = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      n++;
      if (i == 0) begin
        addr = $urandom; wdata = $urandom; sel = 4'($urandom); we = ~w;
      end
      if (ack) got = 1'b1;
      else check("busy_wait", busy, 1);
    end
    check("ack_seen", got, 1);
    check("latency", n, 4);
    check("busy_ack", busy, 0);
    req = 1'b0;
    @(negedge clk);
    check("ack_pulse", ack, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int a2, n;
    logic got;
    logic [31:0] ra;
    rst = 1'b1; req = 1'b0; req0 = 1'b0; we = 1'b0; addr = '0; sel = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ack", ack, 0);
    check("rst_data", rdata, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_ack0", ack0, 0);

    txn2(1'b1, 32'h10, 4'b1111, 32'h1234_5678);
    txn2(1'b0, 32'h10, 4'b0000, 32'h0);
    txn2(1'b1, 32'h10, 4'b0010, 32'hAABB_CCDD);
    txn2(1'b0, 32'h10, 4'b1111, 32'h0);
    txn2(1'b1, 32'h10, 4'b0000, 32'hFFFF_FFFF);
    txn2(1'b0, 32'h10, 4'b0001, 32'h0);

    // Reset while in WAIT must drop the store and produce no ack.
    txn2(1'b1, 32'h20, 4'b1111, 32'h1111_2222);
    a2 = acks2;
    @(negedge clk);
    we = 1'b1; addr = 32'h20; sel = 4'b1111; wdata = 32'hDEAD_BEEF; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1 check("abort_busy", busy, 0);
    repeat (6) @(negedge clk);
    check("abort_noack", acks2, a2);
    txn2(1'b0, 32'h20, 4'b1111, 32'h0);

    // Address range handling: wrap without the check, error with it.
    txn2(1'b1, 32'h0, 4'b1111, 32'h0BAD_F00D);
    txn2(1'b1, 32'h4, 4'b1111, 32'h5566_7788);
    txn2(1'b1, 32'h1004, 4'b1111, 32'hCAFE_F00D);
    txn2(1'b0, 32'h4, 4'b1111, 32'h0);
    txn2(1'b0, 32'h1000, 4'b1111, 32'h0);

    for (int i = 0; i < 4; i++) begin
      ra = {20'h0, 10'($urandom_range(16, 1023)), 2'b00};
      txn2(1'b1, ra, 4'b1111, $urandom);
      txn2(1'b1, ra, 4'($urandom), $urandom);
      txn2(1'b0, ra, 4'b1111, 32'h0);
    end

    // Zero wait states, request held high through the response cycle.
    @(negedge clk);
    we = 1'b1; addr = 32'h40; sel = 4'b1111; wdata = 32'h0F0F_0F0F; req0 = 1'b1;
    q0.push_back(model(1'b1, 32'h40, 4'b1111, 32'h0F0F_0F0F));
    @(posedge clk);
    n = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      n++;
      if (ack0) got = 1'b1;
    end
    check("b2b_lat", n, 2);
    we = 1'b0; addr = 32'h40; sel = 4'b0000; wdata = 32'h0;
    q0.push_back(model(1'b0, 32'h40, 4'b0000, 32'h0));
    n = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      n++;
      if (ack0) got = 1'b1;
    end
    check("b2b_gap", n, 3);
    req0 = 1'b0;
    @(negedge clk);
    check("b2b_pulse", ack0, 0);

    repeat (3) @(negedge clk);
    check("q2_empty", q2.size(), 0);
    check("q0_empty", q0.size(), 0);
    check("ack0_count", acks0, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
